// File: rtl/knn_seq.sv
// Sequencer for the KNN distance/insertion sorter: clears the sorter, streams
// training points from a synchronous memory into it, then reads out the K ranks.
module knn_seq #(
    parameter int W  = 32,
    parameter int K  = 10,
    parameter int AW = 10,
    parameter int NW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W/2-1:0]    test_x,
    input  logic [W/2-1:0]    test_y,
    input  logic [NW-1:0]     n_train,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [W-1:0]      mem_rdata,
    output logic              srt_rst,
    output logic              srt_valid,
    output logic              srt_done,
    output logic [W/2-1:0]    srt_x1,
    output logic [W/2-1:0]    srt_y1,
    output logic [W/2-1:0]    srt_x2,
    output logic [W/2-1:0]    srt_y2,
    output logic [3:0]        srt_sel,
    input  logic [W/4-1:0]    srt_idx,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W/4-1:0]    res_idx,
    output logic [3:0]        res_rank,
    output logic              res_live,
    output logic              res_last
);
    localparam int XW = W / 2;
    localparam int IW = W / 4;

    typedef enum logic [3:0] {
        IDLE, CLR, FETCH, LATCH, FEED0, FEED1, DRAIN, READ, FIN
    } state_t;

    state_t          state_reg;
    logic [NW-1:0]   ptr_reg;
    logic [NW-1:0]   n_eff_reg;
    logic [NW-1:0]   n_eff_in;
    logic [NW-1:0]   ptr_inc;
    logic [3:0]      rank_reg;
    logic            drain_reg;
    logic [XW-1:0]   x1_reg, y1_reg, x2_reg, y2_reg;
    logic            busy_reg, done_reg, mem_en_reg;
    logic            srt_valid_reg, srt_done_reg, res_valid_reg;

    // Saturate the point count so sorter indices (IW bits) never alias.
    generate
        if (IW >= NW) begin : g_nosat
            assign n_eff_in = n_train;
        end else begin : g_sat
            localparam logic [NW-1:0] CAP = NW'(1) << IW;
            assign n_eff_in = (n_train > CAP) ? CAP : n_train;
        end
    endgenerate

    assign ptr_inc = ptr_reg + NW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            n_eff_reg     <= '0;
            rank_reg      <= '0;
            drain_reg     <= 1'b0;
            x1_reg        <= '0;
            y1_reg        <= '0;
            x2_reg        <= '0;
            y2_reg        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mem_en_reg    <= 1'b0;
            srt_valid_reg <= 1'b0;
            srt_done_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x1_reg       <= test_x;
                        y1_reg       <= test_y;
                        n_eff_reg    <= n_eff_in;
                        done_reg     <= 1'b0;
                        busy_reg     <= 1'b1;
                        srt_done_reg <= 1'b0;
                        state_reg    <= CLR;
                    end
                end
                CLR: begin
                    ptr_reg <= '0;
                    if (n_eff_reg != '0) begin
                        mem_en_reg <= 1'b1;
                        state_reg  <= FETCH;
                    end else begin
                        drain_reg <= 1'b0;
                        state_reg <= DRAIN;
                    end
                end
                FETCH: begin
                    mem_en_reg <= 1'b0;
                    state_reg  <= LATCH;
                end
                LATCH: begin
                    x2_reg        <= mem_rdata[W-1:XW];
                    y2_reg        <= mem_rdata[XW-1:0];
                    srt_valid_reg <= 1'b1;
                    state_reg     <= FEED0;
                end
                FEED0: begin
                    state_reg <= FEED1;
                end
                FEED1: begin
                    srt_valid_reg <= 1'b0;
                    ptr_reg       <= ptr_inc;
                    if (ptr_inc < n_eff_reg) begin
                        mem_en_reg <= 1'b1;
                        state_reg  <= FETCH;
                    end else begin
                        drain_reg <= 1'b0;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Two cycles so the sorter finishes inserting the last point.
                    if (drain_reg) begin
                        srt_done_reg  <= 1'b1;
                        res_valid_reg <= 1'b1;
                        state_reg     <= READ;
                    end else begin
                        drain_reg <= 1'b1;
                    end
                end
                READ: begin
                    if (res_ready) begin
                        if (rank_reg == 4'(K - 1)) begin
                            res_valid_reg <= 1'b0;
                            state_reg     <= FIN;
                        end else begin
                            rank_reg <= rank_reg + 4'd1;
                        end
                    end
                end
                FIN: begin
                    rank_reg  <= '0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign mem_en    = mem_en_reg;
    assign mem_addr  = AW'(ptr_reg);
    assign srt_rst   = rst | (state_reg == CLR);
    assign srt_valid = srt_valid_reg;
    // Held high from READ until the next CLR so the sorted ranks stay readable.
    assign srt_done  = srt_done_reg;
    assign srt_x1    = x1_reg;
    assign srt_y1    = y1_reg;
    assign srt_x2    = x2_reg;
    assign srt_y2    = y2_reg;
    assign srt_sel   = rank_reg;
    assign res_valid = res_valid_reg;
    assign res_idx   = srt_idx;
    assign res_rank  = rank_reg;
    assign res_live  = (NW'(rank_reg) < n_eff_reg) && (rank_reg < 4'(K));
    assign res_last  = (rank_reg == 4'(K - 1));
endmodule

// File: tb/tb_knn_seq.sv
// Directed bench for knn_seq with a behavioural insertion-sorter and a
// synchronous training memory attached.
module tb_knn_seq;
    localparam int W = 32, K = 10, AW = 10, NW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   test_x = '0, test_y = '0;
    logic [15:0]   n_train = '0;
    logic          busy, done, mem_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata = '0;
    logic          srt_rst, srt_valid, srt_done;
    logic [15:0]   srt_x1, srt_y1, srt_x2, srt_y2;
    logic [3:0]    srt_sel;
    logic [7:0]    srt_idx;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [7:0]    res_idx;
    logic [3:0]    res_rank;
    logic          res_live, res_last;

    int errors = 0;
    int checks = 0;

    knn_seq #(.W(W), .K(K), .AW(AW), .NW(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .test_x(test_x), .test_y(test_y),
        .n_train(n_train), .busy(busy), .done(done), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .srt_rst(srt_rst),
        .srt_valid(srt_valid), .srt_done(srt_done), .srt_x1(srt_x1),
        .srt_y1(srt_y1), .srt_x2(srt_x2), .srt_y2(srt_y2), .srt_sel(srt_sel),
        .srt_idx(srt_idx), .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_rank(res_rank), .res_live(res_live),
        .res_last(res_last)
    );

    always #5 clk = ~clk;

    // Training memory, one-cycle read latency.
    logic [W-1:0] mem [1024];
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    // Sorter model: inserts on the second of each pair of valid beats.
    logic [7:0] s_idx [10];
    longint     s_dist [10];
    int         s_cnt;
    logic       s_phase;
    always @(posedge clk) begin : sorter_model
        longint dx, dy, d;
        int pos;
        if (srt_rst) begin
            for (int j = 0; j < 10; j++) begin
                s_idx[j]  <= '0;
                s_dist[j] <= 64'h7fff_ffff_ffff_ffff;
            end
            s_cnt   <= 0;
            s_phase <= 1'b0;
        end else if (srt_valid && !srt_done) begin
            s_phase <= !s_phase;
            if (s_phase) begin
                dx = longint'($signed(srt_x1)) - longint'($signed(srt_x2));
                dy = longint'($signed(srt_y1)) - longint'($signed(srt_y2));
                d = dx * dx + dy * dy;
                pos = 10;
                for (int j = 9; j >= 0; j--) if (d < s_dist[j]) pos = j;
                for (int j = 1; j < 10; j++) begin
                    if (j > pos) begin
                        s_idx[j]  <= s_idx[j-1];
                        s_dist[j] <= s_dist[j-1];
                    end
                end
                if (pos < 10) begin
                    s_idx[pos]  <= 8'(s_cnt);
                    s_dist[pos] <= d;
                end
                s_cnt <= s_cnt + 1;
            end
        end
    end
    assign srt_idx = (srt_sel < 4'd10) ? s_idx[srt_sel] : 8'd0;

    int fetch_cnt = 0;
    int clr_cnt = 0;
    int last_addr = -1;
    always @(posedge clk) begin
        if (mem_en) begin
            fetch_cnt <= fetch_cnt + 1;
            last_addr <= int'(mem_addr);
        end
        if (srt_rst && !rst) clr_cnt <= clr_cnt + 1;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [15:0] tx, input logic [15:0] ty, input logic [15:0] n);
        start = 1'b1; test_x = tx; test_y = ty; n_train = n;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int lat0, output int lat);
        lat = lat0;
        while (!res_valid && lat < 2000) begin
            step();
            lat++;
        end
    endtask

    task automatic read_all(input string tag, input logic [7:0] e [10], input int n_live, input bit bp);
        int r = 0;
        int cyc = 0;
        bit tog = 1'b0;
        bit stalled = 1'b0;
        logic [7:0] h_idx = '0;
        logic [3:0] h_rank = '0;
        while (r < 10 && cyc < 500) begin
            res_ready = bp ? tog : 1'b1;
            tog = !tog;
            if (res_valid) begin
                if (stalled) begin
                    chk({tag, "_hold_idx"}, res_idx, h_idx);
                    chk({tag, "_hold_rank"}, res_rank, h_rank);
                end
                if (res_ready) begin
                    chk({tag, "_rank"}, res_rank, r);
                    chk({tag, "_idx"}, res_idx, e[r]);
                    chk({tag, "_live"}, res_live, (r < n_live) ? 1 : 0);
                    chk({tag, "_last"}, res_last, (r == 9) ? 1 : 0);
                    r++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_idx = res_idx;
                    h_rank = res_rank;
                end
            end
            step();
            cyc++;
        end
        res_ready = 1'b0;
        chk({tag, "_beats"}, r, 10);
    endtask

    task automatic finish_chk(input string tag);
        chk({tag, "_fin_done"}, done, 0);
        step();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_srt_done_idle"}, srt_done, 1);
    endtask

    task automatic load_basic();
        mem[0] = {16'sd3, 16'sd4};
        mem[1] = {16'sd1, 16'sd1};
        mem[2] = {16'sd5, 16'sd0};
        mem[3] = {16'sd0, 16'sd2};
    endtask

    initial begin
        logic [7:0] e_basic [10];
        logic [7:0] e_zero [10];
        logic [7:0] e_sat [10];
        logic [7:0] e_b [10];
        int lat, f0, c0;

        e_basic = '{8'd1, 8'd3, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e_zero  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e_sat   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        e_b     = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        load_basic();

        // Reset state
        step(); step();
        chk("rst_srt_rst", srt_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_srt_valid", srt_valid, 0);
        chk("rst_srt_done", srt_done, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_srt_sel", srt_sel, 0);
        rst = 1'b0;
        step();

        // Basic run
        f0 = fetch_cnt; c0 = clr_cnt;
        pulse_start(16'd0, 16'd0, 16'd4);
        chk("basic_busy", busy, 1);
        chk("basic_x1", srt_x1, 0);
        wait_valid(1, lat);
        chk("basic_latency", lat, 20);
        read_all("basic", e_basic, 4, 1'b0);
        finish_chk("basic");
        chk("basic_fetches", fetch_cnt - f0, 4);
        chk("basic_clr", clr_cnt - c0, 1);
        $display("basic run: latency=%0d fetches=%0d", lat, fetch_cnt - f0);

        // Backpressure
        pulse_start(16'd0, 16'd0, 16'd4);
        wait_valid(1, lat);
        chk("bp_latency", lat, 20);
        read_all("bp", e_basic, 4, 1'b1);
        finish_chk("bp");
        $display("backpressure run done");

        // Zero count
        f0 = fetch_cnt;
        pulse_start(16'd0, 16'd0, 16'd0);
        wait_valid(1, lat);
        chk("zero_latency", lat, 4);
        read_all("zero", e_zero, 0, 1'b0);
        finish_chk("zero");
        chk("zero_fetches", fetch_cnt - f0, 0);
        $display("zero run: latency=%0d", lat);

        // Saturation
        for (int i = 0; i < 1024; i++) mem[i] = {16'(i), 16'd0};
        f0 = fetch_cnt;
        pulse_start(16'd0, 16'd0, 16'd300);
        wait_valid(1, lat);
        chk("sat_latency", lat, 1 + 4 * 256 + 2 + 1);
        chk("sat_fetches", fetch_cnt - f0, 256);
        chk("sat_last_addr", last_addr, 255);
        read_all("sat", e_sat, 10, 1'b0);
        finish_chk("sat");
        $display("saturation run: fetches=%0d", fetch_cnt - f0);

        // Abort during FEED0 of point 2
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        load_basic();
        pulse_start(16'd0, 16'd0, 16'd4);
        lat = 0;
        while (!(mem_en && mem_addr == 10'd2) && lat < 200) begin
            step();
            lat++;
        end
        chk("abort_reach_pt2", (lat < 200) ? 1 : 0, 1);
        step(); step();
        chk("abort_in_feed", srt_valid, 1);
        rst = 1'b1;
        #1;
        chk("abort_srt_rst", srt_rst, 1);
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_srt_valid", srt_valid, 0);
        pulse_start(16'd0, 16'd0, 16'd4);
        wait_valid(1, lat);
        chk("abort_rerun_latency", lat, 20);
        read_all("abort_rerun", e_basic, 4, 1'b0);
        finish_chk("abort_rerun");
        $display("abort and rerun done");

        // Back-to-back: run A with an ignored start, then run B with signed data
        c0 = clr_cnt;
        pulse_start(16'd0, 16'd0, 16'd4);
        step(); step(); step();
        pulse_start(16'hFFFB, 16'hFFFB, 16'd2);
        chk("a_x1_kept", srt_x1, 0);
        wait_valid(5, lat);
        chk("a_latency", lat, 20);
        read_all("runa", e_basic, 4, 1'b0);
        start = 1'b1; test_x = 16'hFFFB; test_y = 16'hFFFB; n_train = 16'd2;
        step();
        start = 1'b0;
        chk("a_done", done, 1);
        step();
        chk("fin_start_ignored", busy, 0);
        chk("a_clr", clr_cnt - c0, 1);
        mem[0] = {16'hFFFC, 16'hFFFC};
        mem[1] = {16'sd10, 16'sd10};
        c0 = clr_cnt;
        pulse_start(16'hFFFB, 16'hFFFB, 16'd2);
        wait_valid(1, lat);
        chk("b_latency", lat, 12);
        read_all("runb", e_b, 2, 1'b0);
        finish_chk("runb");
        chk("b_clr", clr_cnt - c0, 1);
        $display("back-to-back runs done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
